// File: rtl/led_sequencer_ctrl.sv
// Avalon-MM LED bank sequencer: static, blink or chase patterns with an optional one-shot step count.
// A hardware alarm request takes over the LED bank and freezes any running pattern until it is released.
module led_sequencer_ctrl #(
    parameter int               WIDTH        = 14,
    parameter int               PRESC_W      = 24,
    parameter logic [PRESC_W-1:0] RESET_PERIOD = 24'd49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              alarm_req,
    output logic [WIDTH-1:0]  led_out,
    output logic              irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ALARM} state_t;

    state_t             state_reg,     state_next;
    logic [WIDTH-1:0]   direct_reg,    direct_next;
    logic [4:0]         ctrl_reg,      ctrl_next;
    logic [PRESC_W-1:0] period_reg,    period_next;
    logic [7:0]         count_reg,     count_next;
    logic               done_reg,      done_next;
    logic [PRESC_W-1:0] presc_reg,     presc_next;
    logic [7:0]         remain_reg,    remain_next;
    logic               phase_reg,     phase_next;
    logic [WIDTH-1:0]   chase_reg,     chase_next;
    logic               alarm_led_reg, alarm_led_next;

    logic wr_en;
    logic ctrl_wr;
    logic tick;
    logic unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == 3'd1);
    assign tick      = (presc_reg == '0);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            direct_reg    <= '0;
            ctrl_reg      <= '0;
            period_reg    <= RESET_PERIOD;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            presc_reg     <= '0;
            remain_reg    <= '0;
            phase_reg     <= 1'b0;
            chase_reg     <= '0;
            alarm_led_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            direct_reg    <= direct_next;
            ctrl_reg      <= ctrl_next;
            period_reg    <= period_next;
            count_reg     <= count_next;
            done_reg      <= done_next;
            presc_reg     <= presc_next;
            remain_reg    <= remain_next;
            phase_reg     <= phase_next;
            chase_reg     <= chase_next;
            alarm_led_reg <= alarm_led_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        direct_next    = direct_reg;
        ctrl_next      = ctrl_reg;
        period_next    = period_reg;
        count_next     = count_reg;
        done_next      = done_reg;
        presc_next     = presc_reg;
        remain_next    = remain_reg;
        phase_next     = phase_reg;
        chase_next     = chase_reg;
        alarm_led_next = alarm_led_reg;

        if (wr_en) begin
            case (address)
                3'd0:    direct_next = writedata[WIDTH-1:0];
                3'd1:    ctrl_next   = writedata[4:0];
                3'd2:    period_next = writedata[PRESC_W-1:0];
                3'd3:    count_next  = writedata[7:0];
                3'd4:    if (writedata[1]) done_next = 1'b0;
                default: ;
            endcase
        end

        case (state_reg)
            ST_IDLE: begin
                if (alarm_req) begin
                    state_next     = ST_ALARM;
                    presc_next     = period_reg;
                    alarm_led_next = 1'b1;
                end else if (ctrl_wr && writedata[0]) begin
                    state_next  = ST_RUN;
                    presc_next  = period_reg;
                    remain_next = count_reg;
                    phase_next  = 1'b0;
                    chase_next  = WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (alarm_req) begin
                    state_next     = ST_ALARM;
                    presc_next     = period_reg;
                    alarm_led_next = 1'b1;
                end else if (ctrl_wr && !writedata[0]) begin
                    state_next = ST_IDLE;
                end else if (ctrl_reg[3] && remain_reg == 8'd0) begin
                    // One-shot armed with a zero count finishes immediately.
                    state_next   = ST_IDLE;
                    done_next    = 1'b1;
                    ctrl_next[0] = 1'b0;
                end else if (tick) begin
                    presc_next = period_reg;
                    phase_next = ~phase_reg;
                    chase_next = {chase_reg[WIDTH-2:0], chase_reg[WIDTH-1]};
                    if (ctrl_reg[3]) begin
                        remain_next = remain_reg - 8'd1;
                        if (remain_reg == 8'd1) begin
                            state_next   = ST_IDLE;
                            done_next    = 1'b1;
                            ctrl_next[0] = 1'b0;
                        end
                    end
                end else begin
                    presc_next = presc_reg - PRESC_W'(1);
                end
            end
            ST_ALARM: begin
                if (alarm_req) begin
                    if (tick) begin
                        presc_next     = period_reg;
                        alarm_led_next = ~alarm_led_reg;
                    end else begin
                        presc_next = presc_reg - PRESC_W'(1);
                    end
                end else begin
                    // Exit decision sees any CTRL write landing this cycle.
                    presc_next = period_reg;
                    state_next = ctrl_next[0] ? ST_RUN : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        led_out = direct_reg;
        case (state_reg)
            ST_RUN: begin
                case (ctrl_reg[2:1])
                    2'd1:    led_out = phase_reg ? '0 : direct_reg;
                    2'd2:    led_out = chase_reg;
                    default: led_out = direct_reg;
                endcase
            end
            ST_ALARM: led_out = alarm_led_reg ? '1 : '0;
            default:  led_out = direct_reg;
        endcase
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = 32'(direct_reg);
            3'd1:    readdata = 32'(ctrl_reg);
            3'd2:    readdata = 32'(period_reg);
            3'd3:    readdata = 32'((state_reg == ST_IDLE) ? count_reg : remain_reg);
            3'd4:    readdata = {29'd0, state_reg == ST_ALARM, done_reg, state_reg == ST_RUN};
            default: readdata = 32'd0;
        endcase
    end

    assign irq = done_reg & ctrl_reg[4];

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Scoreboard bench for led_sequencer_ctrl: stimulus queues expected values, a negedge monitor
// pops and compares them against readdata, led_out or irq.
module tb_led_sequencer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic        alarm_req = 1'b0;
    wire  [31:0] readdata;
    wire  [13:0] led_out;
    wire         irq;

    led_sequencer_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .alarm_req  (alarm_req),
        .led_out    (led_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    localparam int SEL_RD  = 0;
    localparam int SEL_LED = 1;
    localparam int SEL_IRQ = 2;

    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_name[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_strobe = 1'b0;

    int          m_sel;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        if (chk_strobe) begin
            while (q_sel.size() > 0) begin
                m_sel  = q_sel.pop_front();
                m_exp  = q_exp.pop_front();
                m_name = q_name.pop_front();
                case (m_sel)
                    SEL_RD:  m_act = readdata;
                    SEL_LED: m_act = {18'd0, led_out};
                    default: m_act = {31'd0, irq};
                endcase
                n_checks++;
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", m_name, m_act, m_exp);
                end else begin
                    $display("check %s ok 0x%0h", m_name, m_act);
                end
            end
        end
    end

    task automatic expect_val(input int sel, input string name, input logic [31:0] exp);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic expect_rd(input logic [2:0] addr, input string name, input logic [31:0] exp);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        expect_val(SEL_RD, name, exp);
    endtask

    task automatic step();
        chk_strobe = 1'b1;
        @(posedge clk);
        #1;
        chk_strobe = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_alarm[10];
        exp_alarm = '{32'h8, 32'h3FFF, 32'h3FFF, 32'h0, 32'h0,
                      32'h3FFF, 32'h3FFF, 32'h0, 32'h0, 32'h3FFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_val(SEL_LED, "led_in_reset", 32'h0);
        step();
        reset_n = 1'b1;
        expect_rd(3'd0, "rst_direct", 32'h0);
        expect_val(SEL_LED, "rst_led", 32'h0);
        expect_val(SEL_IRQ, "rst_irq", 32'h0);
        step();
        expect_rd(3'd1, "rst_ctrl", 32'h0);
        step();
        expect_rd(3'd2, "rst_period", 32'd49999);
        step();
        expect_rd(3'd3, "rst_count", 32'h0);
        step();
        expect_rd(3'd4, "rst_status", 32'h0);
        step();

        // Static DIRECT value
        wr(3'd0, 32'h0000_2A5A);
        expect_rd(3'd0, "direct_rb", 32'h2A5A);
        expect_val(SEL_LED, "direct_led", 32'h2A5A);
        step();

        // Chase with PERIOD=3: each position held 4 clocks, wrapping after 0x2000
        wr(3'd2, 32'd3);
        wr(3'd1, 32'h5);
        for (int s = 0; s < 15; s++) begin
            for (int c = 0; c < 4; c++) begin
                expect_val(SEL_LED, $sformatf("chase_s%0d_c%0d", s, c), 32'(1) << (s % 14));
                step();
            end
        end
        wr(3'd1, 32'h0);
        expect_val(SEL_LED, "disable_led", 32'h2A5A);
        expect_rd(3'd4, "disable_status", 32'h0);
        step();

        // Blink one-shot, 3 steps, PERIOD=1, irq enabled
        wr(3'd0, 32'h00FF);
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd3);
        wr(3'd1, 32'h1B);
        expect_val(SEL_LED, "blink_c0", 32'hFF);
        expect_rd(3'd3, "remain_3", 32'd3);
        step();
        expect_val(SEL_LED, "blink_c1", 32'hFF);
        expect_rd(3'd4, "blink_busy", 32'h1);
        step();
        expect_val(SEL_LED, "blink_c2", 32'h0);
        expect_rd(3'd3, "remain_2", 32'd2);
        step();
        expect_val(SEL_LED, "blink_c3", 32'h0);
        step();
        expect_val(SEL_LED, "blink_c4", 32'hFF);
        expect_rd(3'd3, "remain_1", 32'd1);
        step();
        expect_val(SEL_LED, "blink_c5", 32'hFF);
        step();
        expect_val(SEL_LED, "oneshot_idle_led", 32'hFF);
        expect_rd(3'd4, "oneshot_status_done", 32'h2);
        expect_val(SEL_IRQ, "oneshot_irq", 32'h1);
        step();
        expect_rd(3'd1, "oneshot_ctrl_en_clr", 32'h1A);
        step();
        wr(3'd4, 32'h2);
        expect_val(SEL_IRQ, "w1c_irq", 32'h0);
        expect_rd(3'd4, "w1c_status", 32'h0);
        step();

        // Chase at PERIOD=1 up to 0x0008, then alarm for 10 clocks
        wr(3'd1, 32'h5);
        for (int c = 0; c < 7; c++) begin
            expect_val(SEL_LED, $sformatf("prealarm_c%0d", c), 32'(1) << (c / 2));
            step();
        end
        alarm_req = 1'b1;
        for (int a = 0; a < 10; a++) begin
            expect_val(SEL_LED, $sformatf("alarm_c%0d", a), 32'(exp_alarm[a]));
            if (a == 5) expect_rd(3'd4, "alarm_status", 32'h4);
            step();
        end
        alarm_req = 1'b0;
        expect_val(SEL_LED, "alarm_exit_c10", 32'h3FFF);
        step();
        expect_val(SEL_LED, "resume_c11", 32'h8);
        expect_rd(3'd4, "resume_status", 32'h1);
        step();
        expect_val(SEL_LED, "resume_c12", 32'h8);
        step();
        expect_val(SEL_LED, "resume_c13", 32'h10);
        expect_rd(3'd1, "ctrl_before_reset", 32'h5);
        step();

        // Asynchronous reset between clock edges
        #1;
        reset_n = 1'b0;
        expect_val(SEL_LED, "async_rst_led", 32'h0);
        expect_rd(3'd1, "async_rst_ctrl", 32'h0);
        expect_val(SEL_IRQ, "async_rst_irq", 32'h0);
        step();
        reset_n = 1'b1;
        expect_rd(3'd2, "post_rst_period", 32'd49999);
        step();

        chipselect = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (q_sel.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
